slv_mon_capture: RTL and testbench



---
 rtl/slv_mon_capture_pkg.sv | 19 +
 rtl/slv_mon_capture_if.sv | 38 +++
 rtl/slv_mon_capture_fifo.sv | 48 ++++
 rtl/slv_mon_capture.sv | 158 +++++++++++++++
 tb/tb_slv_mon_capture.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/slv_mon_capture_pkg.sv
// ============================================================================
// Module   : slv_pkg
// Purpose  : Shared constants and helpers for the slave handshake monitor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package slv_pkg;

  localparam int MON_DROP_W = 16;

  // Channel-index width, never below one bit so NCH=1 still has a legal port.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/slv_mon_capture_if.sv
// ============================================================================
// Module   : slv_mon_capture_if
// Purpose  : Snooped channel bundle plus merged output stream of the monitor.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface slv_mon_capture_if #(
  parameter int NCH    = 4,
  parameter int DATA_W = 32,
  parameter int TS_W   = 16
);
  localparam int CH_W = slv_pkg::ch_width(NCH);

  logic [NCH-1:0]                  mon_valid;
  logic [NCH-1:0]                  mon_ready;
  logic [NCH*DATA_W-1:0]           mon_data;
  logic                            out_valid;
  logic                            out_ready;
  logic [DATA_W-1:0]               out_data;
  logic [CH_W-1:0]                 out_ch;
  logic [TS_W-1:0]                 out_ts;
  logic [NCH-1:0]                  ovf;
  logic [slv_pkg::MON_DROP_W-1:0]  drop_cnt;

  modport slave (
    input  mon_valid, mon_ready, mon_data, out_ready,
    output out_valid, out_data, out_ch, out_ts, ovf, drop_cnt
  );

  modport master (
    output mon_valid, mon_ready, mon_data, out_ready,
    input  out_valid, out_data, out_ch, out_ts, ovf, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/slv_mon_capture_fifo.sv
// ============================================================================
// Module   : slv_mon_fifo
// Purpose  : Single-clock synchronous FIFO with extra-MSB full/empty pointers.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module slv_mon_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         push_i,
  input  wire logic         pop_i,
  input  wire logic [W-1:0] din_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [W-1:0]      dout_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q;
  logic [AW:0]  rd_q;
  logic [W-1:0] mem_q [DEPTH];

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end

endmodule

`default_nettype wire

// File: rtl/slv_mon_capture.sv
// ============================================================================
// Module   : slv_mon_capture
// Purpose  : Captures completed valid/ready transfers on NCH snooped channels
//            into per-channel FIFOs and merges them round-robin onto one stream.
//            Define SLV_MON_TS_EN to store and present a capture timestamp.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module slv_mon_capture
  import slv_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  slv_mon_capture_if.slave  mon
);

  localparam int CH_W = ch_width(NCH);
  localparam int ND_W = $clog2(NCH + 1);

`ifdef SLV_MON_TS_EN
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } entry_t;
`else
  typedef struct packed {
    logic [DATA_W-1:0] data;
  } entry_t;
`endif

  localparam int ENT_W = $bits(entry_t);

  logic [NCH-1:0]        fire, full, empty, push, pop, drop;
  entry_t                fifo_din  [NCH];
  entry_t                fifo_dout [NCH];
  logic                  any, load;
  logic [CH_W-1:0]       grant, cand, ptr_q, ptr_d;
  logic                  out_valid_q;
  logic [DATA_W-1:0]     out_data_q;
  logic [CH_W-1:0]       out_ch_q;
  logic [NCH-1:0]        ovf_q;
  logic [MON_DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [ND_W-1:0]       ndrop;
  logic [MON_DROP_W:0]   drop_sum;

`ifdef SLV_MON_TS_EN
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] out_ts_q;

  always_ff @(posedge clk) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + TS_W'(1);
  end
`endif

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign fire[i] = mon.mon_valid[i] & mon.mon_ready[i];
      // A full FIFO still takes the push when the arbiter drains it this cycle.
      assign push[i] = fire[i] & (~full[i] | pop[i]);
      assign drop[i] = fire[i] & full[i] & ~pop[i];
      assign pop[i]  = load & (grant == CH_W'(i));
      assign fifo_din[i].data = mon.mon_data[i*DATA_W +: DATA_W];
`ifdef SLV_MON_TS_EN
      assign fifo_din[i].ts = ts_q;
`endif

      slv_mon_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push[i]),
        .pop_i   (pop[i]),
        .din_i   (fifo_din[i]),
        .full_o  (full[i]),
        .empty_o (empty[i]),
        .dout_o  (fifo_dout[i])
      );
    end
  endgenerate

  // Scan from the far end so the candidate closest to ptr_q wins.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    cand  = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      cand = CH_W'((int'(ptr_q) + k) % NCH);
      if (!empty[cand]) begin
        any   = 1'b1;
        grant = cand;
      end
    end
  end

  assign load  = (~out_valid_q | mon.out_ready) & any;
  assign ptr_d = (int'(grant) == NCH - 1) ? '0 : grant + CH_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= fifo_dout[grant].data;
      out_ch_q    <= grant;
      ptr_q       <= ptr_d;
    end else if (mon.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef SLV_MON_TS_EN
  always_ff @(posedge clk) begin
    if (rst)       out_ts_q <= '0;
    else if (load) out_ts_q <= fifo_dout[grant].ts;
  end
  assign mon.out_ts = out_ts_q;
`else
  assign mon.out_ts = '0;
`endif

  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NCH; i++) ndrop = ndrop + ND_W'(drop[i]);
    drop_sum   = {1'b0, drop_cnt_q} + (MON_DROP_W + 1)'(ndrop);
    drop_cnt_d = drop_sum[MON_DROP_W] ? '1 : drop_sum[MON_DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      ovf_q      <= ovf_q | drop;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign mon.out_valid = out_valid_q;
  assign mon.out_data  = out_data_q;
  assign mon.out_ch    = out_ch_q;
  assign mon.ovf       = ovf_q;
  assign mon.drop_cnt  = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_slv_mon_capture.sv
// ============================================================================
// Module   : tb_slv_mon_capture
// Purpose  : Self-checking bench for slv_mon_capture against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_slv_mon_capture;

  localparam int NCH    = 4;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 16;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [TS_W-1:0]   ts;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  slv_mon_capture_if #(.NCH(NCH), .DATA_W(DATA_W), .TS_W(TS_W)) bus ();

  slv_mon_capture #(
    .NCH    (NCH),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  ent_t              mq [NCH][$];
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  int                m_ch;
  logic [TS_W-1:0]   m_ts;
  logic [NCH-1:0]    m_ovf;
  int                m_drop;
  int                m_ptr;
  int                m_tick;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [TS_W-1:0] ts_now();
`ifdef SLV_MON_TS_EN
    return TS_W'(m_tick);
`else
    return '0;
`endif
  endfunction

  // One clock: drive inputs, advance the reference model, compare after the edge.
  task automatic step(input logic rst_v, input logic [NCH-1:0] v, input logic [NCH-1:0] r,
                      input logic [NCH*DATA_W-1:0] d, input logic ordy);
    int   g;
    ent_t e;
    rst           = rst_v;
    bus.mon_valid = v;
    bus.mon_ready = r;
    bus.mon_data  = d;
    bus.out_ready = ordy;
    @(posedge clk);
    if (rst_v) begin
      for (int c = 0; c < NCH; c++) mq[c].delete();
      m_valid = 1'b0; m_data = '0; m_ch = 0; m_ts = '0;
      m_ovf = '0; m_drop = 0; m_ptr = 0; m_tick = 0;
    end else begin
      if (!m_valid || ordy) begin
        g = -1;
        for (int k = 0; k < NCH; k++)
          if (g < 0 && mq[(m_ptr + k) % NCH].size() > 0) g = (m_ptr + k) % NCH;
        if (g >= 0) begin
          e = mq[g].pop_front();
          m_valid = 1'b1; m_data = e.d; m_ts = e.ts; m_ch = g;
          m_ptr = (g + 1) % NCH;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (v[c] && r[c]) begin
          if (mq[c].size() < DEPTH) begin
            e.d = d[c*DATA_W +: DATA_W];
            e.ts = ts_now();
            mq[c].push_back(e);
          end else begin
            m_ovf[c] = 1'b1;
            if (m_drop < 65535) m_drop++;
          end
        end
      end
      m_tick++;
    end
    #1;
    check_eq("out_valid", 64'(bus.out_valid), 64'(m_valid));
    if (m_valid) begin
      check_eq("out_data", 64'(bus.out_data), 64'(m_data));
      check_eq("out_ch", 64'(bus.out_ch), 64'(m_ch));
      check_eq("out_ts", 64'(bus.out_ts), 64'(m_ts));
    end
    check_eq("ovf", 64'(bus.ovf), 64'(m_ovf));
    check_eq("drop_cnt", 64'(bus.drop_cnt), 64'(m_drop));
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, ordy);
  endtask

  task automatic fire_one(input int ch, input logic [DATA_W-1:0] val, input logic ordy);
    logic [NCH*DATA_W-1:0] d;
    logic [NCH-1:0]        m;
    d = '0;
    d[ch*DATA_W +: DATA_W] = val;
    m = '0;
    m[ch] = 1'b1;
    step(1'b0, m, m, d, ordy);
  endtask

  initial begin
    logic [NCH*DATA_W-1:0] d;
    logic [NCH-1:0]        v, r;
    int pv [4] = '{30, 60, 90, 100};
    int po [4] = '{100, 50, 20, 70};

    // Reset state
    step(1'b1, '0, '0, '0, 1'b0);
    step(1'b1, '0, '0, '0, 1'b0);
    check_eq("rst_out_data", 64'(bus.out_data), 64'h0);
    check_eq("rst_out_ch", 64'(bus.out_ch), 64'h0);
    check_eq("rst_out_ts", 64'(bus.out_ts), 64'h0);

    // Single capture, one-cycle load latency
    idle(8, 1'b1);
    fire_one(0, 32'hA5A5_0001, 1'b1);
    check_eq("t1_early_valid", 64'(bus.out_valid), 64'h0);
    idle(1, 1'b1);
    check_eq("t1_valid", 64'(bus.out_valid), 64'h1);
    check_eq("t1_data", 64'(bus.out_data), 64'hA5A5_0001);
    check_eq("t1_ch", 64'(bus.out_ch), 64'h0);

    // Simultaneous capture on all channels from a fresh pointer
    step(1'b1, '0, '0, '0, 1'b1);
    for (int i = 0; i < NCH; i++) d[i*DATA_W +: DATA_W] = DATA_W'(i);
    step(1'b0, '1, '1, d, 1'b1);
    for (int k = 0; k < NCH; k++) begin
      idle(1, 1'b1);
      check_eq("t2_ch", 64'(bus.out_ch), 64'(k));
      check_eq("t2_data", 64'(bus.out_data), 64'(k));
    end
    idle(2, 1'b1);

    // Backpressure: 1 held + DEPTH queued, then two drops
    for (int i = 0; i < DEPTH + 3; i++) fire_one(1, $urandom, 1'b0);
    idle(1, 1'b0);
    check_eq("t3_drop", 64'(bus.drop_cnt), 64'd2);
    check_eq("t3_ovf", 64'(bus.ovf), 64'b0010);
    idle(DEPTH + 4, 1'b1);

    // Full FIFO accepts a push on the cycle it is popped
    for (int i = 0; i < DEPTH + 1; i++) fire_one(2, $urandom, 1'b0);
    fire_one(2, 32'hC0DE_0002, 1'b1);
    check_eq("t4_drop", 64'(bus.drop_cnt), 64'd2);
    check_eq("t4_ovf2", 64'(bus.ovf[2]), 64'h0);
    idle(DEPTH + 4, 1'b1);

    // Reset with entries pending
    for (int i = 0; i < NCH; i++) d[i*DATA_W +: DATA_W] = $urandom;
    step(1'b0, '1, '1, d, 1'b0);
    fire_one(0, $urandom, 1'b0);
    step(1'b1, '1, '1, d, 1'b0);
    check_eq("t5_valid", 64'(bus.out_valid), 64'h0);
    check_eq("t5_ovf", 64'(bus.ovf), 64'h0);
    check_eq("t5_drop", 64'(bus.drop_cnt), 64'h0);
    for (int i = 0; i < 5; i++) begin
      idle(1, 1'b1);
      check_eq("t5_stale", 64'(bus.out_valid), 64'h0);
    end

    // Randomized traffic with occasional resets
    for (int s = 0; s < 4; s++) begin
      for (int n = 0; n < 400; n++) begin
        for (int c = 0; c < NCH; c++) begin
          v[c] = ($urandom_range(0, 99) < pv[s]);
          r[c] = ($urandom_range(0, 99) < 70);
          d[c*DATA_W +: DATA_W] = $urandom;
        end
        step($urandom_range(0, 299) == 0, v, r, d,
             $urandom_range(0, 99) < po[s]);
      end
      idle(3 * DEPTH * NCH / 2, 1'b1);
    end

`ifdef SLV_MON_TS_EN
    // Timestamps at 3, at the top of the range, and after wrap
    step(1'b1, '0, '0, '0, 1'b1);
    while (m_tick != 3) idle(1, 1'b1);
    fire_one(3, 32'h0000_0003, 1'b1);
    while (m_tick != 65535) idle(1, 1'b1);
    fire_one(3, 32'h0000_FFFF, 1'b1);
    fire_one(3, 32'h0001_0000, 1'b1);
    idle(4, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
